// File: rtl/pixel_binarizer.sv
// pixel_binarizer: thresholds a grayscale raster stream to one bit per pixel and pads each frame for a 3x3 filter.
// Define BINARIZER_AUTO_THR_EN to load the frame mean into the pending threshold at the end of each frame.
module pixel_binarizer #(
  parameter int WIDTH     = 256,
  parameter int HEIGHT    = 128,
  parameter int PIX_BITS  = 8,
  parameter int ADDR_BITS = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIX_BITS-1:0]  in_pixel,
  input  logic [PIX_BITS-1:0]  threshold,
  input  logic                 thr_load,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic [ADDR_BITS-1:0] bit_addr,
  output logic                 bit_flush,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 busy
);
  localparam int N         = WIDTH * HEIGHT;
  localparam int FLUSH_LEN = 2 * WIDTH + 2;
  localparam int FB        = $clog2(FLUSH_LEN);
  localparam logic [PIX_BITS-1:0] THR_RST = {1'b1, {(PIX_BITS-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t                r_state, w_next;
  logic [PIX_BITS-1:0]   r_pending, r_active, w_thr, w_mean;
  logic [ADDR_BITS-1:0]  r_pix_cnt;
  logic [FB-1:0]         r_flush_cnt;
  logic                  w_accept, w_last, w_flush_end, w_auto;
  assign in_ready    = !reset && (r_state == IDLE || r_state == RUN);
  assign busy        = r_state != IDLE;
  assign w_accept    = in_valid && in_ready;
  assign w_last      = r_pix_cnt == ADDR_BITS'(N - 1);
  assign w_flush_end = r_flush_cnt == FB'(FLUSH_LEN - 1);
  // A load coinciding with the first accept is bypassed so that frame already uses it
  assign w_thr = r_state == IDLE ? (thr_load ? threshold : r_pending) : r_active;
`ifdef BINARIZER_AUTO_THR_EN
  localparam int SUM_BITS = PIX_BITS + ADDR_BITS;
  logic [SUM_BITS-1:0] r_sum;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_sum <= '0;
    else if (w_accept) r_sum <= (r_state == IDLE ? '0 : r_sum) + SUM_BITS'(in_pixel);
  assign w_auto = r_state == FLUSH && w_flush_end;
  assign w_mean = PIX_BITS'(r_sum >> ADDR_BITS);
`else
  assign w_auto = 1'b0;
  assign w_mean = r_pending;
`endif
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, RUN: if (w_accept) w_next = w_last ? FLUSH : RUN;
      FLUSH:     if (w_flush_end) w_next = DONE;
      DONE:      w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state     <= IDLE;
      r_pending   <= THR_RST;
      r_active    <= THR_RST;
      r_pix_cnt   <= '0;
      r_flush_cnt <= '0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      bit_addr    <= '0;
      bit_flush   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_pending   <= thr_load ? threshold : w_auto ? w_mean : r_pending;
      if (w_accept && r_state == IDLE) r_active <= w_thr;
      if (w_accept) r_pix_cnt <= w_last ? '0 : r_pix_cnt + ADDR_BITS'(1);
      r_flush_cnt <= (r_state == FLUSH && !w_flush_end) ? r_flush_cnt + FB'(1) : '0;
      bit_out     <= w_accept && (in_pixel >= w_thr);
      bit_valid   <= w_accept || r_state == FLUSH;
      bit_addr    <= r_state == FLUSH ? ADDR_BITS'(N - 1) : w_accept ? r_pix_cnt : bit_addr;
      bit_flush   <= r_state == FLUSH;
      frame_start <= w_accept && r_state == IDLE;
      frame_done  <= r_state == DONE;
    end
endmodule

// File: tb/tb_pixel_binarizer.sv
// tb_pixel_binarizer: directed vectors and whole frames on a reduced 64x32 raster.
// Frames check every bit against a small threshold model; a table covers bypass and stall corners.
module tb_pixel_binarizer;
  localparam int W = 64, H = 32, PB = 8, AB = 11, N = W * H, FL = 2 * W + 2;
  logic clock = 1'b0, reset = 1'b0, in_valid = 1'b0, thr_load = 1'b0;
  logic [PB-1:0] in_pixel = '0, threshold = '0;
  logic in_ready, bit_out, bit_valid, bit_flush, frame_start, frame_done, busy;
  logic [AB-1:0] bit_addr;
  int n_chk = 0, n_fail = 0, m_sum = 0;
  logic [7:0] m_pend = 8'd128, m_act = 8'd128;
  typedef struct {logic v; logic [7:0] p; logic ld; logic [7:0] thr; logic ev; logic eb; int ea; logic es;} vec_t;
  vec_t tv[8];

  pixel_binarizer #(.WIDTH(W), .HEIGHT(H), .PIX_BITS(PB), .ADDR_BITS(AB)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .threshold(threshold), .thr_load(thr_load), .bit_out(bit_out), .bit_valid(bit_valid),
    .bit_addr(bit_addr), .bit_flush(bit_flush), .frame_start(frame_start), .frame_done(frame_done),
    .busy(busy));

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    thr_load = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", bit_valid, 0);
    chk("rst_bit", bit_out, 0);
    chk("rst_addr", bit_addr, 0);
    chk("rst_flush", bit_flush, 0);
    chk("rst_start", frame_start, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    step;
    reset = 1'b0;
    #1;
    chk("rel_ready", in_ready, 1);
    chk("rel_busy", busy, 0);
    m_pend = 8'd128;
    m_act = 8'd128;
  endtask

  task automatic run_frame(input int k0, input int gap, input int load_at, input logic [7:0] load_val,
                           input int abort_at, input int mode, input logic [7:0] cval);
    int k = k0, steps = 0, nv = 0, guard = 0;
    logic [7:0] p;
    while (k < N && guard < 8 * N) begin
      guard++;
      if (k == abort_at) begin
        do_reset;
        return;
      end
      if (gap != 0 && $urandom_range(1) == 0) begin
        in_valid = 1'b0;
        in_pixel = 8'hff;
        step;
        steps++;
        nv += int'(bit_valid);
        chk("stall_valid", bit_valid, 0);
        continue;
      end
      p = mode != 0 ? cval : k[7:0];
      chk("data_ready", in_ready, 1);
      in_valid = 1'b1;
      in_pixel = p;
      thr_load = k == load_at;
      threshold = load_val;
      if (k == load_at) m_pend = load_val;
      if (k == 0) begin
        m_act = m_pend;
        m_sum = 0;
      end
      m_sum += int'(p);
      step;
      steps++;
      thr_load = 1'b0;
      nv += int'(bit_valid);
      chk("data_valid", bit_valid, 1);
      chk("data_bit", bit_out, int'(p >= m_act));
      chk("data_addr", bit_addr, k);
      chk("data_flush", bit_flush, 0);
      chk("frame_start", frame_start, int'(k == 0));
      chk("early_done", frame_done, 0);
      chk("data_busy", busy, 1);
      k++;
    end
    if (k < N) begin
      chk("frame_progress", k, N);
      return;
    end
    in_valid = 1'b1;
    in_pixel = 8'hff;
    for (int f = 0; f < FL; f++) begin
      chk("flush_ready", in_ready, 0);
      step;
      steps++;
      nv += int'(bit_valid);
      chk("flush_valid", bit_valid, 1);
      chk("flush_bit", bit_out, 0);
      chk("flush_flag", bit_flush, 1);
      chk("flush_addr", bit_addr, N - 1);
    end
    chk("done_state_ready", in_ready, 0);
    step;
    steps++;
    chk("frame_done", frame_done, 1);
    chk("done_valid", bit_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_ready", in_ready, 1);
    chk("bit_count", nv + k0, N + FL);
    if (gap == 0 && k0 == 0) chk("done_cycle", steps, N + FL + 1);
    in_valid = 1'b0;
    step;
    chk("done_pulse", frame_done, 0);
`ifdef BINARIZER_AUTO_THR_EN
    m_pend = 8'(m_sum >> AB);
`endif
  endtask

  initial begin
    tv[0] = '{1'b1, 8'd10,  1'b1, 8'd10,  1'b1, 1'b1, 0, 1'b1};
    tv[1] = '{1'b1, 8'd9,   1'b0, 8'd0,   1'b1, 1'b0, 1, 1'b0};
    tv[2] = '{1'b0, 8'd255, 1'b0, 8'd0,   1'b0, 1'b0, 0, 1'b0};
    tv[3] = '{1'b1, 8'd10,  1'b0, 8'd0,   1'b1, 1'b1, 2, 1'b0};
    tv[4] = '{1'b1, 8'd100, 1'b1, 8'd255, 1'b1, 1'b1, 3, 1'b0};
    tv[5] = '{1'b1, 8'd9,   1'b0, 8'd0,   1'b1, 1'b0, 4, 1'b0};
    tv[6] = '{1'b0, 8'd0,   1'b0, 8'd0,   1'b0, 1'b0, 0, 1'b0};
    tv[7] = '{1'b1, 8'd0,   1'b0, 8'd0,   1'b1, 1'b0, 5, 1'b0};
    @(negedge clock);
    do_reset;
    run_frame(0, 0, 700, 8'd200, -1, 0, 8'd0);
    run_frame(0, 1, -1, 8'd0, -1, 0, 8'd0);
    run_frame(0, 0, -1, 8'd0, 1000, 0, 8'd0);
    run_frame(0, 0, -1, 8'd0, -1, 0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      in_valid = tv[i].v;
      in_pixel = tv[i].p;
      thr_load = tv[i].ld;
      threshold = tv[i].thr;
      step;
      thr_load = 1'b0;
      chk("tbl_valid", bit_valid, int'(tv[i].ev));
      if (tv[i].ev) begin
        chk("tbl_bit", bit_out, int'(tv[i].eb));
        chk("tbl_addr", bit_addr, tv[i].ea);
        chk("tbl_start", frame_start, int'(tv[i].es));
      end
    end
    m_act = 8'd10;
    m_pend = 8'd255;
    m_sum = 10 + 9 + 10 + 100 + 9 + 0;
    run_frame(6, 0, -1, 8'd0, -1, 0, 8'd0);
`ifdef BINARIZER_AUTO_THR_EN
    do_reset;
    run_frame(0, 0, -1, 8'd0, -1, 1, 8'd60);
    run_frame(0, 0, -1, 8'd0, -1, 0, 8'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
